// File: rtl/ccmult_pipe.sv
// rtl/ccmult_pipe.sv - 3-stage streaming complex multiplier (a*b or a*conj(b)), round + optional clamp.
// Define CCMULT_SAT_EN to clamp out-of-range results and report ovf; otherwise results wrap.
module ccmult_pipe #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 12,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_conj,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [WIDTH-1:0] ar,
  input  logic [WIDTH-1:0] ai,
  input  logic [WIDTH-1:0] br,
  input  logic [WIDTH-1:0] bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] pr,
  output logic [WIDTH-1:0] pi,
  output logic [TAG_W-1:0] out_tag,
  output logic             ovf
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = 2 * WIDTH + 2;
  localparam logic signed [SW-1:0] RND = SW'(1) << (FRAC - 1);
`ifdef CCMULT_SAT_EN
  localparam logic signed [SW-1:0] SAT_MAX = (SW'(1) << (WIDTH - 1)) - SW'(1);
  localparam logic signed [SW-1:0] SAT_MIN = -(SW'(1) << (WIDTH - 1));
`endif

  logic                 adv;
  logic                 s1_valid, s1_conj, s2_valid;
  logic [TAG_W-1:0]     s1_tag, s2_tag;
  logic signed [PW-1:0] s1_rr, s1_ii, s1_ri, s1_ir;
  logic signed [SW-1:0] s2_re, s2_im;
  logic signed [SW-1:0] rr_x, ii_x, ri_x, ir_x, re_n, im_n;
  logic signed [SW-1:0] re_sh, im_sh;

  // One shared advance: the whole pipe moves or the whole pipe holds, bubbles included.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  function automatic logic [WIDTH-1:0] narrow(input logic signed [SW-1:0] v);
`ifdef CCMULT_SAT_EN
    if (v > SAT_MAX)      narrow = SAT_MAX[WIDTH-1:0];
    else if (v < SAT_MIN) narrow = SAT_MIN[WIDTH-1:0];
    else                  narrow = v[WIDTH-1:0];
`else
    narrow = v[WIDTH-1:0];
`endif
  endfunction

`ifdef CCMULT_SAT_EN
  function automatic logic clipped(input logic signed [SW-1:0] v);
    clipped = (v > SAT_MAX) || (v < SAT_MIN);
  endfunction
`endif

  always_comb begin
    rr_x = s1_rr;
    ii_x = s1_ii;
    ri_x = s1_ri;
    ir_x = s1_ir;
    if (s1_conj) begin
      re_n = rr_x + ii_x;
      im_n = ir_x - ri_x;
    end else begin
      re_n = rr_x - ii_x;
      im_n = ri_x + ir_x;
    end
    // Round half toward +inf before dropping the fraction.
    re_sh = (s2_re + RND) >>> FRAC;
    im_sh = (s2_im + RND) >>> FRAC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_conj   <= 1'b0;
      s1_tag    <= '0;
      s1_rr     <= '0;
      s1_ii     <= '0;
      s1_ri     <= '0;
      s1_ir     <= '0;
      s2_valid  <= 1'b0;
      s2_tag    <= '0;
      s2_re     <= '0;
      s2_im     <= '0;
      out_valid <= 1'b0;
      out_tag   <= '0;
      pr        <= '0;
      pi        <= '0;
      ovf       <= 1'b0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s1_conj   <= in_conj;
      s1_tag    <= in_tag;
      s1_rr     <= $signed(ar) * $signed(br);
      s1_ii     <= $signed(ai) * $signed(bi);
      s1_ri     <= $signed(ar) * $signed(bi);
      s1_ir     <= $signed(ai) * $signed(br);
      s2_valid  <= s1_valid;
      s2_tag    <= s1_tag;
      s2_re     <= re_n;
      s2_im     <= im_n;
      out_valid <= s2_valid;
      out_tag   <= s2_tag;
      pr        <= narrow(re_sh);
      pi        <= narrow(im_sh);
`ifdef CCMULT_SAT_EN
      ovf       <= clipped(re_sh) || clipped(im_sh);
`else
      ovf       <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_ccmult_pipe.sv
// tb/tb_ccmult_pipe.sv - directed self-checking bench for ccmult_pipe (WIDTH=16, FRAC=12).
module tb_ccmult_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_conj;
  logic [3:0]  in_tag;
  logic [15:0] ar, ai, br, bi;
  logic        out_valid, out_ready;
  logic [15:0] pr, pi;
  logic [3:0]  out_tag;
  logic        ovf;

  int checks = 0;
  int failures = 0;

  ccmult_pipe #(.WIDTH(16), .FRAC(12), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_conj(in_conj), .in_tag(in_tag), .ar(ar), .ai(ai), .br(br), .bi(bi),
    .out_valid(out_valid), .out_ready(out_ready), .pr(pr), .pi(pi),
    .out_tag(out_tag), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Drives one sample, then reports edges-to-out_valid (99 on timeout) and the captured result.
  task automatic issue(input int a_r, a_i, b_r, b_i, input logic cj, input logic [3:0] tg,
                       output int lat, output logic [15:0] o_pr, o_pi,
                       output logic [3:0] o_tag, output logic o_ovf);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_conj = cj; in_tag = tg;
    ar = 16'(a_r); ai = 16'(a_i); br = 16'(b_r); bi = 16'(b_i);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = 99;
    o_pr = pr; o_pi = pi; o_tag = out_tag; o_ovf = ovf;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_conj = 1'b0; in_tag = '0;
    ar = '0; ai = '0; br = '0; bi = '0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (pr !== 16'd0) begin failures++; $display("FAIL reset_pr got=%0d exp=0", pr); end
    checks++; if (pi !== 16'd0) begin failures++; $display("FAIL reset_pi got=%0d exp=0", pi); end
    checks++; if (out_tag !== 4'd0) begin failures++; $display("FAIL reset_tag got=%0d exp=0", out_tag); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int lat; logic [15:0] r, i; logic [3:0] t; logic o;
    issue(4096, 0, 0, 4096, 1'b0, 4'd5, lat, r, i, t, o);
    checks++; if (lat !== 3) begin failures++; $display("FAIL basic_latency got=%0d exp=3", lat); end
    checks++; if (r !== 16'd0) begin failures++; $display("FAIL basic_pr got=%0d exp=0", $signed(r)); end
    checks++; if (i !== 16'd4096) begin failures++; $display("FAIL basic_pi got=%0d exp=4096", $signed(i)); end
    checks++; if (t !== 4'd5) begin failures++; $display("FAIL basic_tag got=%0d exp=5", t); end
    checks++; if (o !== 1'b0) begin failures++; $display("FAIL basic_ovf got=%b exp=0", o); end
  endtask

  task automatic test_conj;
    int lat; logic [15:0] r, i; logic [3:0] t; logic o;
    issue(0, 4096, 0, 4096, 1'b1, 4'd1, lat, r, i, t, o);
    checks++; if (r !== 16'd4096) begin failures++; $display("FAIL conj1_pr got=%0d exp=4096", $signed(r)); end
    checks++; if (i !== 16'd0) begin failures++; $display("FAIL conj1_pi got=%0d exp=0", $signed(i)); end
    checks++; if (t !== 4'd1) begin failures++; $display("FAIL conj1_tag got=%0d exp=1", t); end
    issue(0, 4096, 0, 4096, 1'b0, 4'd2, lat, r, i, t, o);
    checks++; if (r !== 16'hF000) begin failures++; $display("FAIL conj0_pr got=%0d exp=-4096", $signed(r)); end
    checks++; if (i !== 16'd0) begin failures++; $display("FAIL conj0_pi got=%0d exp=0", $signed(i)); end
    checks++; if (t !== 4'd2) begin failures++; $display("FAIL conj0_tag got=%0d exp=2", t); end
  endtask

  task automatic test_rounding;
    int lat; logic [15:0] r, i; logic [3:0] t; logic o;
    issue(1, 0, 2048, 0, 1'b0, 4'd3, lat, r, i, t, o);
    checks++; if (r !== 16'd1) begin failures++; $display("FAIL round_pos_pr got=%0d exp=1", $signed(r)); end
    checks++; if (i !== 16'd0) begin failures++; $display("FAIL round_pos_pi got=%0d exp=0", $signed(i)); end
    issue(-1, 0, 2048, 0, 1'b0, 4'd4, lat, r, i, t, o);
    checks++; if (r !== 16'd0) begin failures++; $display("FAIL round_neg_pr got=%0d exp=0", $signed(r)); end
    checks++; if (i !== 16'd0) begin failures++; $display("FAIL round_neg_pi got=%0d exp=0", $signed(i)); end
  endtask

  task automatic test_saturation;
    int lat; logic [15:0] r, i; logic [3:0] t; logic o;
    logic [15:0] exp_pr; logic exp_ovf;
`ifdef CCMULT_SAT_EN
    exp_pr = 16'd32767; exp_ovf = 1'b1;
`else
    exp_pr = 16'd0; exp_ovf = 1'b0;
`endif
    issue(-32768, 0, -32768, 0, 1'b0, 4'd6, lat, r, i, t, o);
    checks++; if (r !== exp_pr) begin failures++; $display("FAIL sat_pr got=%0d exp=%0d", $signed(r), $signed(exp_pr)); end
    checks++; if (i !== 16'd0) begin failures++; $display("FAIL sat_pi got=%0d exp=0", $signed(i)); end
    checks++; if (o !== exp_ovf) begin failures++; $display("FAIL sat_ovf got=%b exp=%b", o, exp_ovf); end
  endtask

  // Six samples back-to-back, out_ready low in cycles 4..8; sample k gives pr=256k, pi=-128k.
  task automatic test_backpressure;
    int nxt = 0, got = 0;
    logic stalled = 1'b0;
    logic [15:0] h_pr = '0, h_pi = '0;
    logic [3:0]  h_tag = '0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc <= 8);
      in_valid = (nxt < 6);
      in_conj = 1'b0; in_tag = 4'(nxt);
      ar = 16'd4096; ai = 16'd0; br = 16'(nxt * 256); bi = 16'(-nxt * 128);
      #1;
      checks++;
      if (in_ready !== out_ready) begin
        failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, out_ready);
      end
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || pr !== h_pr || pi !== h_pi || out_tag !== h_tag) begin
          failures++;
          $display("FAIL bp_hold cyc=%0d got=%b/%0d/%0d/%0d exp=1/%0d/%0d/%0d",
                   cyc, out_valid, $signed(pr), $signed(pi), out_tag, $signed(h_pr), $signed(h_pi), h_tag);
        end
      end
      stalled = out_valid && !out_ready;
      h_pr = pr; h_pi = pi; h_tag = out_tag;
      if (out_valid && out_ready) begin
        checks++;
        if (out_tag !== 4'(got) || pr !== 16'(got * 256) || pi !== 16'(-got * 128)) begin
          failures++;
          $display("FAIL bp_result idx=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                   got, out_tag, $signed(pr), $signed(pi), got, got * 256, -got * 128);
        end
        got++;
      end
      if (in_valid && in_ready) nxt++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (got !== 6) begin failures++; $display("FAIL bp_count got=%0d exp=6", got); end
  endtask

  task automatic test_reset_midstream;
    int lat; logic [15:0] r, i; logic [3:0] t; logic o;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_conj = 1'b0; in_tag = 4'(8 + k);
      ar = 16'd4096; ai = 16'd0; br = 16'd0; bi = 16'd4096;
      @(posedge clk);
    end
    #2;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
    checks++; if (pr !== 16'd0 || pi !== 16'd0) begin failures++; $display("FAIL rstmid_data got=%0d/%0d exp=0/0", pr, pi); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    issue(4096, 0, 0, 4096, 1'b0, 4'd12, lat, r, i, t, o);
    checks++; if (lat !== 3) begin failures++; $display("FAIL rstmid_latency got=%0d exp=3", lat); end
    checks++; if (i !== 16'd4096 || t !== 4'd12) begin failures++; $display("FAIL rstmid_result got=%0d/%0d exp=4096/12", $signed(i), t); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_conj;
    test_rounding;
    test_saturation;
    test_backpressure;
    test_reset_midstream;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
